rv32i_mem_arbiter: RTL

Two-requester arbiter for a single-port synchronous memory, one read/write access per cycle. Sits between the rv32i core's memory interface (port 0) and a secondary master such as a program loader or MMIO DMA (port 1), and shares one `mem_addr`/`mem_wr_data`/`mem_wr_ena`/`mem_rd_data` memory port between them. Arbitration is fixed priority (port 0 wins), with an optional starvation guard for port 1. Read data returns one cycle after the grant, tagged to the requester that was granted.

---
 rtl/rv32i_mem_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/rv32i_mem_arbiter.sv
// Two-port fixed-priority arbiter in front of a single-port synchronous memory.
// Optional port-1 starvation guard compiled in with MEM_ARB_STARVE_GUARD_EN.
module rv32i_mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_ena,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    owner_t rd_owner;
    owner_t rd_owner_nxt;
    logic   force1;

    if (STARVE_LIMIT == 0 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("rv32i_mem_arbiter: STARVE_LIMIT must be in 1..255");
    end

    // Grants are killed combinationally while rst is high.
    assign gnt0 = ~rst & req0 & ~force1;
    assign gnt1 = ~rst & req1 & (~req0 | force1);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;

    // Counts consecutive denied port-1 cycles, saturating at LIMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (gnt1 | ~req1) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    assign force1 = req1 & (starve_cnt == LIMIT);
`else
    assign force1 = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner <= OWN_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
        end
    end

    // Read owner follows whichever port was granted a read this cycle.
    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (gnt0 & ~we0) begin
            rd_owner_nxt = OWN_P0;
        end else if (gnt1 & ~we1) begin
            rd_owner_nxt = OWN_P1;
        end
    end

    assign rvalid0 = (rd_owner == OWN_P0);
    assign rvalid1 = (rd_owner == OWN_P1);
    assign rdata0  = mem_rd_data;
    assign rdata1  = mem_rd_data;

    // Port 0 drives the memory bus unless port 1 holds the grant.
    assign mem_addr    = gnt1 ? addr1  : addr0;
    assign mem_wr_data = gnt1 ? wdata1 : wdata0;
    assign mem_wr_ena  = (gnt0 & we0) | (gnt1 & we1);

    assign busy = req0 | req1 | (rd_owner != OWN_NONE);

endmodule
